// File: rtl/matrix_add_sub_unit_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg : shared matrix geometry, engine opcodes and unit state encoding
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package matrix_pkg;

  localparam int ELEM_W = 16;
  localparam int DIM    = 4;
  localparam int BUS_W  = 256;
  localparam int ROW_W  = DIM * ELEM_W;
  localparam int CNT_W  = $clog2(DIM);

  localparam logic [3:0] SUM = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE_A = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/matrix_add_sub_unit_row_add_sub.sv
// ---------------------------------------------------------------------------
// row_add_sub : one matrix row of DIM wrap-around add/sub lanes with overflow
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module row_add_sub
  import matrix_pkg::*;
(
  input  logic [ROW_W-1:0] a_row,
  input  logic [ROW_W-1:0] b_row,
  input  logic             sub,
  output logic [ROW_W-1:0] sum_row,
  output logic [DIM-1:0]   ovf
);

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [ELEM_W-1:0] a;
    logic [ELEM_W-1:0] b;
    logic [ELEM_W-1:0] s;

    assign a = a_row[i*ELEM_W +: ELEM_W];
    assign b = b_row[i*ELEM_W +: ELEM_W];
    assign s = sub ? (a - b) : (a + b);
    assign sum_row[i*ELEM_W +: ELEM_W] = s;
    // Subtraction overflows when operand signs differ, addition when they agree.
    assign ovf[i] = (sub ? (a[ELEM_W-1] != b[ELEM_W-1]) : (a[ELEM_W-1] == b[ELEM_W-1]))
                    && (s[ELEM_W-1] != a[ELEM_W-1]);
  end

endmodule

`default_nettype wire

// File: rtl/matrix_add_sub_unit.sv
// ---------------------------------------------------------------------------
// matrix_add_sub_unit : 4x4 element-wise add/sub, one row per cycle
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module matrix_add_sub_unit
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] dataInBus,
  input  logic             ldEn,
  input  logic             subSel,
  input  logic             resAck,
  output logic [BUS_W-1:0] dataOut,
  output logic             resValid,
  output logic             busy,
  output logic             ovfl
);

  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic [BUS_W-1:0]   a_q,       a_d;
  logic [BUS_W-1:0]   b_q,       b_d;
  logic [BUS_W-1:0]   res_q,     res_d;
  logic [BUS_W-1:0]   dout_q,    dout_d;
  logic [3:0]         op_q,      op_d;
  logic               ovfl_q,    ovfl_d;

  logic [ROW_W-1:0]   a_row_w;
  logic [ROW_W-1:0]   b_row_w;
  logic [ROW_W-1:0]   sum_row_w;
  logic [DIM-1:0]     lane_ovf_w;

  assign a_row_w = a_q[row_cnt_q*ROW_W +: ROW_W];
  assign b_row_w = b_q[row_cnt_q*ROW_W +: ROW_W];

  row_add_sub u_row (
    .a_row   (a_row_w),
    .b_row   (b_row_w),
    .sub     (op_q == SUB),
    .sum_row (sum_row_w),
    .ovf     (lane_ovf_w)
  );

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    dout_d    = dout_q;
    op_d      = op_q;
    ovfl_d    = ovfl_q;
    case (state_q)
      IDLE: begin
        if (ldEn) begin
          a_d     = dataInBus;
          ovfl_d  = 1'b0;
          state_d = HAVE_A;
        end
      end
      HAVE_A: begin
        if (ldEn) begin
          b_d       = dataInBus;
          op_d      = subSel ? SUB : SUM;
          row_cnt_d = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        res_d[row_cnt_q*ROW_W +: ROW_W] = sum_row_w;
        ovfl_d    = ovfl_q | (|lane_ovf_w);
        row_cnt_d = row_cnt_q + 1'b1;
        // The last row is merged in here so dataOut never sees a partial matrix.
        if (row_cnt_q == CNT_W'(DIM-1)) begin
          dout_d  = res_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (resAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      dout_q    <= '0;
      op_q      <= SUM;
      ovfl_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      dout_q    <= dout_d;
      op_q      <= op_d;
      ovfl_q    <= ovfl_d;
    end
  end

  assign dataOut  = dout_q;
  assign resValid = (state_q == DONE);
  assign busy     = (state_q == CALC) || (state_q == DONE);
  assign ovfl     = ovfl_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_add_sub_unit.sv
// ---------------------------------------------------------------------------
// tb_matrix_add_sub_unit : directed + random bench with a matrix-level model
// Revision               : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_matrix_add_sub_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] dataInBus;
  logic         ldEn;
  logic         subSel;
  logic         resAck;
  logic [255:0] dataOut;
  logic         resValid;
  logic         busy;
  logic         ovfl;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  matrix_add_sub_unit dut (
    .clk       (clk),
    .rst       (rst),
    .dataInBus (dataInBus),
    .ldEn      (ldEn),
    .subSel    (subSel),
    .resAck    (resAck),
    .dataOut   (dataOut),
    .resValid  (resValid),
    .busy      (busy),
    .ovfl      (ovfl)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Whole-matrix reference: signed integer arithmetic, overflow = out of 16-bit range.
  function automatic void model_op(input logic [255:0] a, input logic [255:0] b, input bit s,
                                   output logic [255:0] r, output bit o);
    int ai, bi, t;
    o = 1'b0;
    r = '0;
    for (int e = 0; e < 16; e++) begin
      ai = $signed(a[e*16 +: 16]);
      bi = $signed(b[e*16 +: 16]);
      t  = s ? ai - bi : ai + bi;
      r[e*16 +: 16] = t[15:0];
      if (t > 32767 || t < -32768) o = 1'b1;
    end
  endfunction

  // Transaction model: phase 0 idle, 1 A held, 2..5 cycles after B, 6 result pending.
  int           m_phase = 0;
  logic [255:0] m_a, m_pend, m_out = '0;
  bit           m_pend_o, m_ovfl = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_a = '0; m_out = '0; m_ovfl = 1'b0;
    end else begin
      case (m_phase)
        0: if (ldEn) begin m_a = dataInBus; m_ovfl = 1'b0; m_phase = 1; end
        1: if (ldEn) begin model_op(m_a, dataInBus, subSel, m_pend, m_pend_o); m_phase = 2; end
        5: begin m_out = m_pend; m_ovfl = m_pend_o; m_phase = 6; end
        6: if (resAck) m_phase = 0;
        default: m_phase = m_phase + 1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, m_phase >= 2);
      chk("resValid", resValid, m_phase == 6);
      chk("dataOut", dataOut, m_out);
      if (m_phase < 2 || m_phase == 6) chk("ovfl", ovfl, m_ovfl);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [255:0] v);
    ldEn = 1'b1; dataInBus = v;
    tick();
    ldEn = 1'b0; dataInBus = '0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!resValid && lat < 30) begin tick(); lat++; end
    if (!resValid) chk("timeout_resValid", 1'b0, 1'b1);
  endtask

  task automatic ack();
    resAck = 1'b1; tick(); resAck = 1'b0;
  endtask

  task automatic op(input logic [255:0] a, input logic [255:0] b, input bit s, output int lat);
    load(a);
    subSel = s;
    load(b);
    subSel = 1'($urandom);
    lat = 1;
    while (!resValid && lat < 30) begin tick(); lat++; end
    if (!resValid) chk("timeout_op", 1'b0, 1'b1);
    lat = lat - 1;
  endtask

  function automatic logic [255:0] rnd_mat(input bit edgy);
    logic [255:0] r;
    logic [15:0]  pick [4];
    pick[0] = 16'h7FFF; pick[1] = 16'h8000; pick[2] = 16'h0001; pick[3] = 16'hFFFF;
    for (int k = 0; k < 16; k++)
      r[k*16 +: 16] = (edgy && $urandom_range(0, 1) == 1) ? pick[$urandom_range(0, 3)]
                                                          : 16'($urandom);
    return r;
  endfunction

  logic [255:0] ones, exp_r;
  bit           exp_o;
  int           lat;

  initial begin
    ones = '1;
    rst = 1'b1; ldEn = 1'b0; subSel = 1'b0; resAck = 1'b0; dataInBus = '0;
    tick();
    cmp_en = 1'b1;
    ldEn = 1'b1; resAck = 1'b1; dataInBus = ones;
    tick();
    ldEn = 1'b0; resAck = 1'b0; rst = 1'b0;
    chk("rst_dataOut", dataOut, '0);
    chk("rst_resValid", resValid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovfl", ovfl, 1'b0);

    op({16{16'd5}}, {16{16'd3}}, 1'b0, lat);
    chk("add_latency", lat, 4);
    chk("add_result", dataOut, {16{16'd8}});
    chk("add_ovfl", ovfl, 1'b0);
    ack();

    op(256'h1, 256'h2, 1'b1, lat);
    chk("sub_wrap", dataOut, 256'hFFFF);
    chk("sub_wrap_ovfl", ovfl, 1'b0);
    ack();

    op({16'h7FFF, 240'h0}, {16'h0001, 240'h0}, 1'b0, lat);
    chk("ovf_result", dataOut, {16'h8000, 240'h0});
    chk("ovf_flag", ovfl, 1'b1);
    ack();
    load(256'h0);
    chk("ovf_cleared", ovfl, 1'b0);
    subSel = 1'b0;
    load(256'h0);
    wait_valid(lat);
    ack();

    // Stray loads during CALC and DONE, then an ack/load collision.
    model_op({16{16'h1234}}, {16{16'h0F0F}}, 1'b1, exp_r, exp_o);
    load({16{16'h1234}});
    subSel = 1'b1;
    load({16{16'h0F0F}});
    ldEn = 1'b1; dataInBus = ones;
    tick(); tick();
    chk("ign_busy", busy, 1'b1);
    ldEn = 1'b0;
    wait_valid(lat);
    ldEn = 1'b1; dataInBus = ones;
    tick();
    ldEn = 1'b0;
    chk("ign_done_busy", busy, 1'b1);
    chk("ign_result", dataOut, exp_r);
    resAck = 1'b1; ldEn = 1'b1;
    tick();
    resAck = 1'b0; ldEn = 1'b0;
    chk("collide_busy", busy, 1'b0);
    chk("collide_valid", resValid, 1'b0);
    resAck = 1'b1; tick(); tick(); resAck = 1'b0;
    chk("ack_idle", busy, 1'b0);
    load(256'h0);
    chk("no_A_captured", busy, 1'b0);
    load(256'h0);
    wait_valid(lat);
    ack();

    // Reset after row 1 has been computed.
    load(rnd_mat(1'b0));
    load(rnd_mat(1'b0));
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_valid", resValid, 1'b0);
    chk("rst_mid_dout", dataOut, '0);
    op({16{16'd5}}, {16{16'd3}}, 1'b0, lat);
    chk("rst_fresh_result", dataOut, {16{16'd8}});
    ack();

    for (int i = 0; i < 30; i++) begin
      load(rnd_mat(i[0]));
      repeat ($urandom_range(0, 2)) tick();
      subSel = 1'($urandom);
      load(rnd_mat(i[1]));
      wait_valid(lat);
      repeat ($urandom_range(0, 2)) tick();
      ack();
      repeat ($urandom_range(0, 1)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_add_sub_unit.md
# matrix_add_sub_unit

Element-wise 4x4 matrix add/subtract unit sitting directly downstream of the execution engine on the shared 256-bit data bus. It serves the SUM (4'b0001) and SUB (4'b0010) instructions the engine decodes. The engine strobes in two operand matrices and selects add or subtract. The unit computes one row per cycle and presents the registered result with a valid flag until the engine acknowledges it.

## Interface
- ELEM_W, 16, element width in bits (two's complement).
- DIM, 4, matrix dimension. DIM*DIM*ELEM_W must equal 256.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- dataInBus  in  256  operand matrix; element (r,c) at bits [(r*DIM+c)*ELEM_W +: ELEM_W].
- ldEn  in  1  capture dataInBus as the next operand this cycle.
- subSel  in  1  sampled with the second operand; 0 = A+B, 1 = A−B.
- resAck  in  1  engine has consumed the result.
- dataOut  out  256  result matrix, registered, same element layout as dataInBus.
- resValid  out  1  result on dataOut is complete and unacknowledged.
- busy  out  1  high in CALC and DONE; ldEn is ignored while high.
- ovfl  out  1  some element of the last operation had signed overflow.

## Operation
- States: IDLE, HAVE_A, CALC, DONE.
- IDLE: on ldEn, capture A ← dataInBus, clear ovfl, go to HAVE_A.
- HAVE_A: on ldEn, capture B ← dataInBus and op ← subSel, set rowCnt=0, go to CALC. Without ldEn, stay indefinitely.
- CALC: each cycle, compute row rowCnt (DIM lanes) into the result register.
  - Set ovfl if any lane overflows; ovfl is sticky until the next A capture.
  - rowCnt increments. After row DIM−1, copy the full result into dataOut and go to DONE.
- DONE: resValid=1. On resAck, go to IDLE. resValid is low from the next cycle; dataOut holds its value.
- Arithmetic:
  - Each lane is ELEM_W-bit modulo 2^ELEM_W (wrap-around, no saturation).
  - Overflow = operand signs agree (add) or differ (sub) and the result sign differs from A's sign.
- dataOut changes only on the CALC→DONE transition, never with a partial result.
- ldEn in CALC or DONE: ignored, no state or data change.
- resAck outside DONE: ignored.
- resAck and ldEn in the same DONE cycle: ack is taken, ldEn is ignored.
- subSel is only sampled with B; its value at other times is irrelevant.

## Timing
- Reset (rst high at an edge): state=IDLE, rowCnt=0, A=B=result=0, dataOut=0, resValid=0, busy=0, ovfl=0.
  - Reset overrides any concurrent ldEn or resAck.
  - Reset mid-CALC discards partial work.
- Cycle numbering: B is captured at edge E; rows 0..3 are computed at edges E+1..E+4.
- dataOut, resValid=1 and final ovfl are visible after edge E+4. Latency is 4 cycles from the B capture.
- busy rises after edge E and falls after the edge at which resAck is sampled in DONE.
- Minimum issue interval, back-to-back with immediate ack: A, B, 4 calc cycles, 1 ack cycle = 7 cycles.

## Structure
- Shared package matrix_pkg holds:
  - ELEM_W, DIM and BUS_W=256.
  - Opcode constants SUM=4'b0001, SUB=4'b0010, used by both the engine and this unit.
  - The state enum {IDLE, HAVE_A, CALC, DONE}.
- One sub-module, row_add_sub: combinational, DIM lanes, inputs a_row, b_row and sub, outputs sum_row and a per-lane ovf vector.
- Top level contains the FSM, rowCnt, operand/result registers, and row select/insert muxing.

## Test plan
- Add: all A elements 5, all B elements 3, subSel=0 → after edge E+4 every dataOut element = 16'd8, resValid=1, ovfl=0.
- Subtract wrap: A(0,0)=16'h0001, B(0,0)=16'h0002, subSel=1, others 0 → dataOut(0,0)=16'hFFFF, others 0, ovfl=0.
- Overflow: A(3,3)=16'h7FFF, B(3,3)=16'h0001, add → dataOut(3,3)=16'h8000, ovfl=1. Next A load clears ovfl to 0.
- Ignored load: pulse ldEn with all-ones data during CALC and in DONE → busy=1, result identical to the undisturbed run, state sequence unchanged.
- Reset mid-op: assert rst after row 1 is computed → next cycle state=IDLE, dataOut=0, resValid=0, busy=0. A fresh 5+3 operation then yields all 8s.
- Ack collision: resAck and ldEn both high in DONE → IDLE next cycle, no A captured; a second resAck held in IDLE has no effect.
